// File: rtl/sram_like_defs.sv
// Shared encodings for the SRAM-like memory responder: access sizes, FSM states, port ids.
// Also holds the byte-strobe helper so the lane rule lives in exactly one place.
// No ports; imported by sram_like_rr_arb and sram_like_mem_slave.
package sram_like_defs;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    typedef enum logic {
        PORT_INST = 1'b0,
        PORT_DATA = 1'b1
    } port_e;

    // Lane strobes come purely from size and the low address bits; misalignment
    // is not detected. Size 3 falls through to a full word.
    function automatic logic [3:0] byte_strobe(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] strb;
        case (size)
            SIZE_BYTE: strb = 4'b0001 << addr_lo;
            SIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
            default:   strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/sram_like_rr_arb.sv
// Two-way round-robin grant between the inst and data request lines.
// Latency: grant is combinational; last_grant updates on the accept edge.
// Backpressure: the loser keeps its request up and wins the next conflict.
// Ports: clk/rst, inst_req/data_req in, accept in (an accept edge is happening), grant out.
import sram_like_defs::*;

module sram_like_rr_arb (
    input  logic  clk,
    input  logic  rst,
    input  logic  inst_req,
    input  logic  data_req,
    input  logic  accept,
    output port_e grant
);

    port_e last_grant_q;
    port_e last_grant_d;

    always_comb begin
        grant = PORT_INST;
        if (inst_req && data_req) begin
            grant = (last_grant_q == PORT_INST) ? PORT_DATA : PORT_INST;
        end else if (data_req) begin
            grant = PORT_DATA;
        end
        last_grant_d = accept ? grant : last_grant_q;
    end

    // Reset to INST so that DATA wins the very first conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= PORT_INST;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/sram_like_mem_slave.sv
// SRAM-like bus responder: arbitrates inst/data ports onto one synchronous word RAM.
// Latency: data_ok pulses LATENCY cycles after the accept edge; a new request can be taken in RESP.
// Backpressure: addr_ok only in IDLE/RESP to the granted requester; one transaction outstanding.
// Ports: clk, rst; inst_*/data_* (req, wr, size, addr, wdata -> rdata, addr_ok, data_ok);
//        ram_en/ram_we/ram_addr/ram_wdata out, ram_rdata in (valid the cycle after ram_en).
import sram_like_defs::*;

module sram_like_mem_slave #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [31:0]       inst_addr,
    input  logic [31:0]       inst_wdata,
    output logic [31:0]       inst_rdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_wdata,
    output logic [31:0]       data_rdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 2);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    port_e             port_q, port_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              cap_q, cap_d;
    logic [31:0]       hold_q, hold_d;
    logic [31:0]       inst_rdata_q, inst_rdata_d;
    logic [31:0]       data_rdata_q, data_rdata_d;

    port_e             grant;
    logic              can_accept;
    logic              accept;
    logic [31:0]       resp_word;

    // Bits above the RAM word address are ignored by design.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{inst_addr[31:ADDR_W+2], data_addr[31:ADDR_W+2]};

    sram_like_rr_arb u_arb (
        .clk      (clk),
        .rst      (rst),
        .inst_req (inst_req),
        .data_req (data_req),
        .accept   (accept),
        .grant    (grant)
    );

    always_comb begin
        can_accept   = (state_q == ST_IDLE) || (state_q == ST_RESP);
        inst_addr_ok = can_accept && inst_req && (grant == PORT_INST);
        data_addr_ok = can_accept && data_req && (grant == PORT_DATA);
        accept       = inst_addr_ok || data_addr_ok;

        state_d = state_q;
        cnt_d   = cnt_q;
        port_d  = port_q;
        wr_d    = wr_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        if (accept) begin
            port_d = grant;
            if (grant == PORT_DATA) begin
                wr_d    = data_wr;
                size_d  = data_size;
                addr_d  = data_addr[ADDR_W+1:0];
                wdata_d = data_wdata;
            end else begin
                wr_d    = inst_wr;
                size_d  = inst_size;
                addr_d  = inst_addr[ADDR_W+1:0];
                wdata_d = inst_wdata;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (LATENCY <= 2) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = accept ? ST_ACCESS : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // The RAM word is only valid in the cycle right after ACCESS; show it
        // directly then (covers RESP at LATENCY=2) and keep it for later cycles.
        cap_d     = (state_q == ST_ACCESS);
        resp_word = cap_q ? ram_rdata : hold_q;
        hold_d    = resp_word;

        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        if (state_q == ST_RESP) begin
            if (port_q == PORT_DATA) data_rdata_d = resp_word;
            else                     inst_rdata_d = resp_word;
        end
        inst_rdata   = inst_rdata_d;
        data_rdata   = data_rdata_d;
        inst_data_ok = (state_q == ST_RESP) && (port_q == PORT_INST);
        data_data_ok = (state_q == ST_RESP) && (port_q == PORT_DATA);

        ram_en    = (state_q == ST_ACCESS);
        ram_we    = (ram_en && wr_q) ? byte_strobe(size_q, addr_q[1:0]) : 4'b0000;
        ram_addr  = addr_q[ADDR_W+1:2];
        ram_wdata = wdata_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            port_q       <= PORT_INST;
            wr_q         <= 1'b0;
            size_q       <= SIZE_WORD;
            addr_q       <= '0;
            wdata_q      <= 32'd0;
            cap_q        <= 1'b0;
            hold_q       <= 32'd0;
            inst_rdata_q <= 32'd0;
            data_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            port_q       <= port_d;
            wr_q         <= wr_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cap_q        <= cap_d;
            hold_q       <= hold_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

endmodule

// File: tb/tb_sram_like_mem_slave.sv
// Bench: four DUTs (LATENCY 2,3,5,15), each with its own RAM, checked against a
// byte-lane memory model, a round-robin grant rule and a busy/latency model.
module tb_sram_like_mem_slave;

    localparam int NK = 4;
    localparam int LAT_TAB [NK] = '{2, 3, 5, 15};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        inst_req [NK];
    logic        inst_wr [NK];
    logic [1:0]  inst_size [NK];
    logic [31:0] inst_addr [NK];
    logic [31:0] inst_wdata [NK];
    logic        data_req [NK];
    logic        data_wr [NK];
    logic [1:0]  data_size [NK];
    logic [31:0] data_addr [NK];
    logic [31:0] data_wdata [NK];
    wire  [31:0] inst_rdata [NK];
    wire         inst_addr_ok [NK];
    wire         inst_data_ok [NK];
    wire  [31:0] data_rdata [NK];
    wire         data_addr_ok [NK];
    wire         data_data_ok [NK];
    wire         ram_en [NK];
    wire  [3:0]  ram_we [NK];
    wire  [11:0] ram_addr [NK];
    wire  [31:0] ram_wdata [NK];

    logic [31:0] ref_mem [NK][4096];
    int          ref_last [NK];   // 0 = inst, 1 = data
    int          checks = 0;
    int          errs = 0;

    for (genvar g = 0; g < NK; g++) begin : g_dut
        logic [31:0] mem [4096];
        logic [31:0] rd_q;
        initial for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
        always @(posedge clk) begin
            if (ram_en[g]) begin
                rd_q <= mem[ram_addr[g]];
                for (int b = 0; b < 4; b++)
                    if (ram_we[g][b]) mem[ram_addr[g]][8*b +: 8] = ram_wdata[g][8*b +: 8];
            end
        end
        sram_like_mem_slave #(.ADDR_W(12), .LATENCY(LAT_TAB[g])) u_dut (
            .clk(clk), .rst(rst),
            .inst_req(inst_req[g]), .inst_wr(inst_wr[g]), .inst_size(inst_size[g]),
            .inst_addr(inst_addr[g]), .inst_wdata(inst_wdata[g]), .inst_rdata(inst_rdata[g]),
            .inst_addr_ok(inst_addr_ok[g]), .inst_data_ok(inst_data_ok[g]),
            .data_req(data_req[g]), .data_wr(data_wr[g]), .data_size(data_size[g]),
            .data_addr(data_addr[g]), .data_wdata(data_wdata[g]), .data_rdata(data_rdata[g]),
            .data_addr_ok(data_addr_ok[g]), .data_data_ok(data_data_ok[g]),
            .ram_en(ram_en[g]), .ram_we(ram_we[g]), .ram_addr(ram_addr[g]),
            .ram_wdata(ram_wdata[g]), .ram_rdata(rd_q)
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic aok(input int k, input int p);
        return (p == 1) ? data_addr_ok[k] : inst_addr_ok[k];
    endfunction
    function automatic logic dok(input int k, input int p);
        return (p == 1) ? data_data_ok[k] : inst_data_ok[k];
    endfunction
    function automatic logic [31:0] rdat(input int k, input int p);
        return (p == 1) ? data_rdata[k] : inst_rdata[k];
    endfunction

    task automatic drive(input int k, input int p, input logic req, input logic wr,
                         input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        if (p == 1) begin
            data_req[k] = req; data_wr[k] = wr; data_size[k] = sz;
            data_addr[k] = a; data_wdata[k] = wd;
        end else begin
            inst_req[k] = req; inst_wr[k] = wr; inst_size[k] = sz;
            inst_addr[k] = a; inst_wdata[k] = wd;
        end
    endtask

    // Byte lanes touched by an access of the given size at the given address.
    function automatic logic [3:0] lanes(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] m;
        m = 4'b0000;
        if (sz == 2'd0)      m[a[1:0]] = 1'b1;
        else if (sz == 2'd1) begin m[{a[1], 1'b0}] = 1'b1; m[{a[1], 1'b1}] = 1'b1; end
        else                 m = 4'b1111;
        return m;
    endfunction

    function automatic logic [31:0] rnd_addr(input int span);
        logic [31:0] r;
        r = $urandom();
        return (r & 32'hFFFF_C000) | 32'($urandom_range(0, span - 1));
    endfunction

    // One isolated transaction: accept, strobe check in ACCESS, exact data_ok cycle.
    task automatic do_txn(input int k, input int p, input logic wr, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd);
        int          lat;
        logic [3:0]  m;
        logic [31:0] exp_rd;
        lat = LAT_TAB[k];
        @(negedge clk);
        drive(k, p, 1'b1, wr, sz, a, wd);
        #1;
        chk("txn_addr_ok", aok(k, p), 1);
        chk("txn_other_addr_ok", aok(k, 1 - p), 0);
        m = wr ? lanes(sz, a) : 4'b0000;
        exp_rd = ref_mem[k][a[13:2]];
        for (int b = 0; b < 4; b++)
            if (m[b]) ref_mem[k][a[13:2]][8*b +: 8] = wd[8*b +: 8];
        ref_last[k] = p;
        for (int n = 1; n <= lat + 1; n++) begin
            @(negedge clk);
            if (n == 1) drive(k, p, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
            #1;
            chk("txn_ram_en", ram_en[k], n == 1);
            if (n == 1) begin
                chk("txn_ram_we", ram_we[k], m);
                chk("txn_ram_addr", ram_addr[k], a[13:2]);
            end
            chk("txn_data_ok", dok(k, p), n == lat);
            chk("txn_other_data_ok", dok(k, 1 - p), 0);
            if (n == lat && !wr) chk("txn_rdata", rdat(k, p), exp_rd);
        end
    endtask

    // Reads with requests held high; grants, addr_ok, data_ok and rdata all
    // predicted every cycle from the one-outstanding / round-robin rules.
    task automatic run_stream(input int k, input int ni, input int nd);
        int          lat, owner, last_acc, win;
        int          rem [2];
        logic [31:0] cur [2];
        logic [31:0] exp_w;
        logic        busy, req_i, req_d, resp, can, e_iok, e_dok, acc, done;
        lat = LAT_TAB[k];
        rem[0] = ni; rem[1] = nd;
        busy = 1'b0; owner = 0; last_acc = 0; exp_w = 32'd0; done = 1'b0; acc = 1'b0;
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            cur[p] = rnd_addr(64) & 32'hFFFF_FFFC;
            drive(k, p, rem[p] > 0, 1'b0, 2'd2, cur[p], 32'd0);
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            #1;
            req_i = rem[0] > 0;
            req_d = rem[1] > 0;
            resp  = busy && (cyc == last_acc + lat);
            can   = !busy || resp;
            win   = (req_i && req_d) ? 1 - ref_last[k] : (req_d ? 1 : 0);
            e_iok = can && req_i && (win == 0);
            e_dok = can && req_d && (win == 1);
            chk("stream_addr_ok_inst", inst_addr_ok[k], e_iok);
            chk("stream_addr_ok_data", data_addr_ok[k], e_dok);
            chk("stream_data_ok_inst", inst_data_ok[k], resp && owner == 0);
            chk("stream_data_ok_data", data_data_ok[k], resp && owner == 1);
            if (resp) begin
                chk("stream_rdata", rdat(k, owner), exp_w);
                busy = 1'b0;
            end
            acc = e_iok || e_dok;
            if (acc) begin
                busy = 1'b1; owner = win; last_acc = cyc; ref_last[k] = win;
                exp_w = ref_mem[k][cur[win][13:2]];
                rem[win]--;
            end
            if (!busy && rem[0] == 0 && rem[1] == 0) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
            if (acc) begin
                cur[owner] = rnd_addr(64) & 32'hFFFF_FFFC;
                drive(k, owner, rem[owner] > 0, 1'b0, 2'd2, cur[owner], 32'd0);
            end
        end
        chk("stream_done", done, 1);
        drive(k, 0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        drive(k, 1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    endtask

    initial begin
        for (int k = 0; k < NK; k++) begin
            drive(k, 0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
            drive(k, 1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
            ref_last[k] = 0;
            for (int i = 0; i < 4096; i++) ref_mem[k][i] = 32'd0;
        end
        #2;
        for (int k = 0; k < NK; k++) begin
            chk("rst_inst_data_ok", inst_data_ok[k], 0);
            chk("rst_data_data_ok", data_data_ok[k], 0);
            chk("rst_inst_rdata", inst_rdata[k], 32'd0);
            chk("rst_data_rdata", data_rdata[k], 32'd0);
            chk("rst_ram_en", ram_en[k], 0);
            chk("rst_ram_we", ram_we[k], 4'd0);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Prefill every RAM with random-size writes, interleaved with reads.
        for (int k = 0; k < NK; k++)
            for (int i = 0; i < 16; i++)
                do_txn(k, $urandom_range(0, 1), i < 10 || i[0], 2'($urandom_range(0, 3)),
                       rnd_addr(64), $urandom());

        // Reset in the middle of WAIT on a data read (LATENCY=5): response is dropped.
        @(negedge clk);
        drive(2, 1, 1'b1, 1'b0, 2'd2, 32'h0000_0100, 32'd0);
        #1;
        chk("rstw_addr_ok", data_addr_ok[2], 1);
        @(negedge clk);
        drive(2, 1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstw_data_ok_now", data_data_ok[2], 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NK; k++) ref_last[k] = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            #1;
            chk("rstw_data_ok", data_data_ok[2], 0);
            chk("rstw_inst_data_ok", inst_data_ok[2], 0);
            chk("rstw_ram_en", ram_en[2], 0);
        end
        @(negedge clk);
        drive(2, 0, 1'b1, 1'b0, 2'd2, 32'd0, 32'd0);
        drive(2, 1, 1'b1, 1'b0, 2'd2, 32'd0, 32'd0);
        #1;
        chk("first_conflict_data", data_addr_ok[2], 1);
        chk("first_conflict_inst", inst_addr_ok[2], 0);
        #1;
        drive(2, 0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
        drive(2, 1, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0);

        // 100 conflicting reads on the LATENCY=2 instance: data, inst, data, ...
        run_stream(0, 50, 50);

        // Directed word/byte/half writes and merged read-back at 0x100.
        do_txn(0, 1, 1'b1, 2'd2, 32'h0000_0100, 32'hDEAD_BEEF);
        do_txn(0, 1, 1'b0, 2'd2, 32'h0000_0100, 32'd0);
        do_txn(0, 1, 1'b1, 2'd0, 32'h0000_0103, 32'hAA00_0000);
        do_txn(0, 1, 1'b1, 2'd1, 32'h0000_0102, 32'h5566_0000);
        do_txn(0, 0, 1'b1, 2'd0, 32'h0000_0101, 32'h0000_7700);
        do_txn(0, 1, 1'b0, 2'd2, 32'h0000_0100, 32'd0);
        do_txn(0, 0, 1'b0, 2'd3, 32'h0000_0100, 32'd0);

        // Back-to-back data reads at LATENCY=3.
        run_stream(1, 0, 4);

        // Latency sweep across all instances with random mixed traffic.
        for (int k = 0; k < NK; k++)
            for (int i = 0; i < 8; i++)
                do_txn(k, $urandom_range(0, 1), 1'($urandom_range(0, 1)),
                       2'($urandom_range(0, 3)), rnd_addr(64), $urandom());
        run_stream(3, 4, 4);
        run_stream(2, 3, 5);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
